// File: rtl/ysyx_23060332_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060332_ifu
// Brief    : Instruction fetch unit. Single-outstanding AR/R read handshake,
//            holds the fetched word for decode, supports redirects and a
//            sticky fetch-error state.
// Revision : 1.0
// ============================================================================
module ysyx_23060332_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]  state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic        flush_q,     flush_d;
  logic [31:0] pending_q,   pending_d;
  logic [31:0] inst_q,      inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        fetch_err_q, fetch_err_d;

  // Redirect targets are always word aligned; the low two bits are dropped.
  logic [31:0] w_target;
  assign w_target = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      flush_q     <= 1'b0;
      pending_q   <= 32'h0;
      inst_q      <= 32'h0;
      inst_addr_q <= 32'h0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      pending_q   <= pending_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_d     = flush_q;
    pending_d   = pending_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_AR;
        if (redirect_en) pc_d = w_target;
      end
      S_AR: begin
        // The issued address must not move, so a redirect is parked until
        // the in-flight response has been drained.
        if (redirect_en) begin
          flush_d   = 1'b1;
          pending_d = w_target;
        end
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) begin
          if (redirect_en) begin
            pc_d    = w_target;
            flush_d = 1'b0;
            state_d = S_AR;
          end else if (flush_q) begin
            pc_d    = pending_q;
            flush_d = 1'b0;
            state_d = S_AR;
          end else if (rresp == 2'b00) begin
            inst_d      = rdata;
            inst_addr_d = pc_q;
            state_d     = S_OUT;
          end else begin
            fetch_err_d = 1'b1;
            state_d     = S_ERR;
          end
        end else if (redirect_en) begin
          flush_d   = 1'b1;
          pending_d = w_target;
        end
      end
      S_OUT: begin
        if (redirect_en) begin
          pc_d    = w_target;
          state_d = S_AR;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_AR;
        end
      end
      S_ERR: begin
        fetch_err_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    arvalid     = (state_q == S_AR);
    rready      = (state_q == S_R);
    inst_valid  = (state_q == S_OUT);
    araddr      = pc_q;
    inst_o      = inst_q;
    inst_addr_o = inst_addr_q;
    fetch_err   = fetch_err_q;
  end

endmodule
`default_nettype wire
